collatz_sweep: RTL and testbench
================================

# collatz_sweep

Parametrised Collatz range engine; next generation of the single-seed orbit block. It accepts a base seed and a seed count, then iterates every seed in the range at one Collatz step per clock. It reports the seed with the longest orbit, the highest value reached, and how many seeds overflowed. It sits behind the chip-level I/O shim, which loads its inputs and reads its registered results.

## Interface
- BITS, 32, width of seeds and iterate values
- OLEN_BITS, 16, width of orbit-length counters
- CNT_BITS, 16, width of seed count and overflow counter
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  stop sweep; sampled in any non-IDLE state
- seed_base  in  BITS  first seed; sampled on accepted start
- seed_count  in  CNT_BITS  number of seeds; sampled on accepted start
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes normally
- best_seed  out  BITS  seed with the longest orbit
- best_len  out  OLEN_BITS  orbit length of best_seed, in steps to reach 1
- peak  out  BITS  largest iterate seen over non-overflowed seeds
- peak_seed  out  BITS  seed that produced peak
- ovf_count  out  CNT_BITS  number of seeds that overflowed
- overflow  out  1  sticky; set when ovf_count is nonzero

## Operation
- States:
  - IDLE: waiting for a sweep.
  - LOAD: iter<=seed, len<=0, lpeak<=seed.
  - RUN: one Collatz step per cycle.
- Reset (asynchronous): state IDLE; every output and internal register is 0.
- Starting a sweep:
  - In IDLE, start=1 with seed_count≠0: latch seed_base and seed_count, clear all result outputs and overflow, go to LOAD.
  - start with seed_count=0: ignored; no busy, no done.
  - start while busy: ignored.
- RUN, each cycle, in priority order:
  - iter==1 or iter==0: commit the seed. Seed 0 is never iterated, and its length is 0.
  - Otherwise, len==2^OLEN_BITS-1: the seed is overflowed.
  - Otherwise, step:
    - even iter: iter>>1
    - odd iter: 3·iter+1, computed at BITS+2 bits
    - a nonzero value in the upper 2 bits overflows the seed
    - lpeak<=max(lpeak,next)
    - len<=len+1
- Commit of a non-overflowed seed:
  - if len>best_len (strictly greater): best_len<=len, best_seed<=seed
  - if lpeak>peak (strictly greater): peak<=lpeak, peak_seed<=seed
  - Ties keep the earlier seed.
- Overflowed seed: ovf_count+1 and overflow<=1. Its len and lpeak are discarded, and the sweep continues.
- After commit or overflow:
  - if seeds remain: seed<=seed+1 (wraps modulo 2^BITS) and go to LOAD
  - else: go to IDLE with done=1
- Abort:
  - in LOAD or RUN: go to IDLE next cycle; no done; results keep their partial values
  - abort and start together in IDLE: start is still accepted, because abort is ignored in IDLE
- Outputs are registered and hold their values until the next accepted start or reset.

## Timing
- busy rises in the cycle after the start edge (the LOAD cycle) and falls in the same cycle done pulses.
- A seed with orbit length L occupies L+2 cycles: 1 LOAD cycle, L step cycles, 1 commit cycle.
- An overflowed seed occupies (steps taken)+2 cycles.
- done is high in cycle Σ(L_i+2)+1, counting the start edge as cycle 0.
- Results are updated on the commit edge and are valid while done=1.
- Reset mid-sweep: immediate return to IDLE with all outputs 0.

## Test plan
- BITS=32; seed_base=27, seed_count=1 -> best_seed=27, best_len=111, peak=9232, peak_seed=27, ovf_count=0; done exactly 114 cycles after the start edge.
- seed_base=1, seed_count=10 -> best_seed=9, best_len=19, peak=52, peak_seed=7, overflow=0; busy low the cycle done pulses.
- seed_base=12, seed_count=2 (tie at length 9) -> best_seed=12, best_len=9.
- BITS=8; seed_base=254, seed_count=3 (seeds 254, 255, 0 with wrap) -> ovf_count≥1, overflow=1; seed 0 commits with len 0; done pulses; no hang.
- Abort in RUN at cycle 50 of seed 27 -> IDLE next cycle, busy=0, no done, best_len=0.
- Same sweep, rst_n low mid-RUN -> all outputs 0 immediately. A start with seed_count=0 -> busy stays 0, no done.

Source files
------------

// File: rtl/collatz_sweep_if.sv
// Bundle of the sweep engine's control and result signals.
// Handshake: start is a request that the engine accepts only while busy is
// low (and seed_count is nonzero). seed_base/seed_count are sampled on the
// accepting edge. busy then stays high until the sweep ends. done pulses for
// one cycle on normal completion, and the results are valid while done is high.
// abort is a level that the engine honours on any edge where busy is high.
interface collatz_sweep_if #(
  parameter int BITS      = 32,
  parameter int OLEN_BITS = 16,
  parameter int CNT_BITS  = 16
);
  logic                 start;
  logic                 abort;
  logic [BITS-1:0]      seed_base;
  logic [CNT_BITS-1:0]  seed_count;
  logic                 busy;
  logic                 done;
  logic [BITS-1:0]      best_seed;
  logic [OLEN_BITS-1:0] best_len;
  logic [BITS-1:0]      peak;
  logic [BITS-1:0]      peak_seed;
  logic [CNT_BITS-1:0]  ovf_count;
  logic                 overflow;

  modport master (
    output start, abort, seed_base, seed_count,
    input  busy, done, best_seed, best_len, peak, peak_seed, ovf_count, overflow
  );

  modport slave (
    input  start, abort, seed_base, seed_count,
    output busy, done, best_seed, best_len, peak, peak_seed, ovf_count, overflow
  );
endinterface

// File: rtl/collatz_sweep.sv
// Collatz range engine: walks seed_base .. seed_base+seed_count-1, one
// Collatz step per clock. It tracks the longest orbit, the highest iterate
// reached by any non-overflowed seed, and the number of seeds that overflowed.
module collatz_sweep #(
  parameter int BITS      = 32,
  parameter int OLEN_BITS = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  collatz_sweep_if.slave   bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [BITS+1:0]      W_ONE = (BITS+2)'(1);
  localparam logic [OLEN_BITS-1:0] L_ONE = OLEN_BITS'(1);
  localparam logic [CNT_BITS-1:0]  C_ONE = CNT_BITS'(1);
  localparam logic [BITS-1:0]      S_ONE = BITS'(1);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [BITS-1:0]      r_seed;
  logic [CNT_BITS-1:0]  r_remain;
  logic [BITS-1:0]      r_iter;
  logic [OLEN_BITS-1:0] r_len;
  logic [BITS-1:0]      r_lpeak;
  logic [BITS-1:0]      r_best_seed;
  logic [OLEN_BITS-1:0] r_best_len;
  logic [BITS-1:0]      r_peak;
  logic [BITS-1:0]      r_peak_seed;
  logic [CNT_BITS-1:0]  r_ovf_count;
  logic                 r_overflow;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_commit;
  logic                 w_ovf_seed;
  logic                 w_step;
  logic                 w_last;
  logic                 w_at_end;
  logic                 w_len_max;
  logic                 w_step_ovf;
  logic [BITS+1:0]      w_wide;
  logic [BITS+1:0]      w_triple;
  logic [BITS+1:0]      w_next;

  // Candidate next iterate, computed two bits wider so 3n+1 cannot wrap silently.
  always_comb begin
    w_wide     = {2'b00, r_iter};
    w_triple   = w_wide + (w_wide << 1) + W_ONE;
    w_next     = r_iter[0] ? w_triple : {3'b000, r_iter[BITS-1:1]};
    w_step_ovf = |w_next[BITS+1:BITS];
    w_at_end   = (r_iter[BITS-1:1] == '0);
    w_len_max  = &r_len;
    w_last     = (r_remain == C_ONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-cycle action decode; abort outranks everything outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_ovf_seed  = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.seed_count != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = bus.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          if (w_at_end)                     w_commit   = 1'b1;
          else if (w_len_max || w_step_ovf) w_ovf_seed = 1'b1;
          else                              w_step     = 1'b1;
          if (w_commit || w_ovf_seed) w_state_nxt = w_last ? S_IDLE : S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: seed cursor, orbit walker and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed      <= '0;
      r_remain    <= '0;
      r_iter      <= '0;
      r_len       <= '0;
      r_lpeak     <= '0;
      r_best_seed <= '0;
      r_best_len  <= '0;
      r_peak      <= '0;
      r_peak_seed <= '0;
      r_ovf_count <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_seed      <= bus.seed_base;
        r_remain    <= bus.seed_count;
        r_best_seed <= '0;
        r_best_len  <= '0;
        r_peak      <= '0;
        r_peak_seed <= '0;
        r_ovf_count <= '0;
        r_overflow  <= 1'b0;
      end
      if (r_state == S_LOAD) begin
        r_iter  <= r_seed;
        r_len   <= '0;
        r_lpeak <= r_seed;
      end
      if (w_step) begin
        r_iter <= w_next[BITS-1:0];
        r_len  <= r_len + L_ONE;
        if (w_next[BITS-1:0] > r_lpeak) r_lpeak <= w_next[BITS-1:0];
      end
      // Strict comparisons so that ties keep the earlier seed.
      if (w_commit) begin
        if (r_len > r_best_len) begin
          r_best_len  <= r_len;
          r_best_seed <= r_seed;
        end
        if (r_lpeak > r_peak) begin
          r_peak      <= r_lpeak;
          r_peak_seed <= r_seed;
        end
      end
      if (w_ovf_seed) begin
        r_ovf_count <= r_ovf_count + C_ONE;
        r_overflow  <= 1'b1;
      end
      if (w_commit || w_ovf_seed) begin
        r_seed   <= r_seed + S_ONE;
        r_remain <= r_remain - C_ONE;
        if (w_last) r_done <= 1'b1;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.best_seed = r_best_seed;
  assign bus.best_len  = r_best_len;
  assign bus.peak      = r_peak;
  assign bus.peak_seed = r_peak_seed;
  assign bus.ovf_count = r_ovf_count;
  assign bus.overflow  = r_overflow;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: a 32-bit and an 8-bit instance share one clock and reset.
module tb_collatz_sweep;

  logic clk;
  logic rst_n;
  logic [1:0] dbg32;
  logic [1:0] dbg8;

  collatz_sweep_if #(.BITS(32), .OLEN_BITS(16), .CNT_BITS(16)) bus32 ();
  collatz_sweep_if #(.BITS(8),  .OLEN_BITS(16), .CNT_BITS(16)) bus8 ();

  collatz_sweep #(.BITS(32), .OLEN_BITS(16), .CNT_BITS(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32), .dbg_state(dbg32));
  collatz_sweep #(.BITS(8), .OLEN_BITS(16), .CNT_BITS(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .dbg_state(dbg8));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     is8;
    longint base;
    int     cnt;
    longint best_seed;
    int     best_len;
    longint peak;
    longint peak_seed;
    int     ovf;
    int     cyc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Walks every seed with plain integer arithmetic; bits sets the value range.
  function automatic void model_sweep(input int bits, input longint base, input int cnt,
                                      inout vec_t v);
    longint lim;
    longint s;
    longint x;
    longint nx;
    longint lp;
    int     len;
    bit     ov;
    lim = longint'(1) << bits;
    s = base;
    v.best_seed = 0; v.best_len = 0; v.peak = 0; v.peak_seed = 0; v.ovf = 0; v.cyc = 1;
    for (int k = 0; k < cnt; k++) begin
      x = s; lp = s; len = 0; ov = 0;
      while (x > 1) begin
        if (len == 65535) begin ov = 1; break; end
        nx = (x % 2 == 0) ? x / 2 : 3 * x + 1;
        if (nx >= lim) begin ov = 1; break; end
        if (nx > lp) lp = nx;
        x = nx;
        len++;
      end
      v.cyc += len + 2;
      if (ov) v.ovf++;
      else begin
        if (len > v.best_len) begin v.best_len = len; v.best_seed = s; end
        if (lp > v.peak)      begin v.peak = lp;      v.peak_seed = s; end
      end
      s = (s + 1) % lim;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit is8, input logic st, input logic ab,
                       input longint base, input int cnt);
    if (is8) begin
      bus8.start = st; bus8.abort = ab; bus8.seed_base = base[7:0]; bus8.seed_count = cnt[15:0];
    end else begin
      bus32.start = st; bus32.abort = ab; bus32.seed_base = base[31:0]; bus32.seed_count = cnt[15:0];
    end
  endtask

  task automatic get_out(input bit is8, output longint bs, output longint bl, output longint pk,
                         output longint ps, output longint oc, output longint ov,
                         output longint busy, output longint done);
    if (is8) begin
      bs = bus8.best_seed; bl = bus8.best_len; pk = bus8.peak; ps = bus8.peak_seed;
      oc = bus8.ovf_count; ov = bus8.overflow; busy = bus8.busy; done = bus8.done;
    end else begin
      bs = bus32.best_seed; bl = bus32.best_len; pk = bus32.peak; ps = bus32.peak_seed;
      oc = bus32.ovf_count; ov = bus32.overflow; busy = bus32.busy; done = bus32.done;
    end
  endtask

  // Launch a sweep and wait for done; cycle 0 is the start edge.
  // poke_cyc>0 re-asserts start (with other inputs) mid-sweep; with_abort raises abort alongside start.
  task automatic run_sweep(input vec_t v, input int poke_cyc, input bit with_abort,
                           output int cyc, output bit seen);
    longint bs, bl, pk, ps, oc, ov, busy, done;
    @(negedge clk);
    drive(v.is8, 1'b1, with_abort, v.base, v.cnt);
    @(posedge clk);
    cyc = 0; seen = 0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) drive(v.is8, 1'b0, 1'b0, v.base, v.cnt);
      if (cyc == poke_cyc) drive(v.is8, 1'b1, 1'b0, v.base + 100, 1);
      if (cyc == poke_cyc + 1) drive(v.is8, 1'b0, 1'b0, v.base, v.cnt);
      get_out(v.is8, bs, bl, pk, ps, oc, ov, busy, done);
      if (cyc == 1) check("busy_in_load", busy, 1);
      if (done == 1) begin
        seen = 1;
        check("busy_low_at_done", busy, 0);
      end
    end
    drive(v.is8, 1'b0, 1'b0, v.base, v.cnt);
  endtask

  // ---------------- scoreboard ----------------
  task automatic apply_vec(input string tag, input vec_t v, input int poke_cyc, input bit with_abort);
    int cyc;
    bit seen;
    longint bs, bl, pk, ps, oc, ov, busy, done;
    run_sweep(v, poke_cyc, with_abort, cyc, seen);
    check({tag, ".done_seen"}, seen, 1);
    check({tag, ".done_cycle"}, cyc, v.cyc);
    get_out(v.is8, bs, bl, pk, ps, oc, ov, busy, done);
    check({tag, ".best_seed"}, bs, v.best_seed);
    check({tag, ".best_len"},  bl, v.best_len);
    check({tag, ".peak"},      pk, v.peak);
    check({tag, ".peak_seed"}, ps, v.peak_seed);
    check({tag, ".ovf_count"}, oc, v.ovf);
    check({tag, ".overflow"},  ov, (v.ovf != 0) ? 1 : 0);
    repeat (2) @(negedge clk);
    get_out(v.is8, bs, bl, pk, ps, oc, ov, busy, done);
    check({tag, ".hold_best_len"}, bl, v.best_len);
    check({tag, ".done_pulse_only"}, done, 0);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    longint bs, bl, pk, ps, oc, ov, busy, done;
    int done_cnt;

    // Vector table: {is8, base, count, best_seed, best_len, peak, peak_seed, ovf, done cycle}
    vecs[0] = '{0, 27, 1, 27, 111, 9232, 27, 0, 114};
    vecs[1] = '{0, 1, 10, 9, 19, 52, 7, 0, 88};
    vecs[2] = '{0, 12, 2, 12, 9, 40, 13, 0, 23};
    vecs[3] = '{1, 254, 3, 0, 0, 0, 0, 2, 8};
    vecs[4] = '{1, 5, 2, 6, 8, 16, 5, 0, 18};

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    get_out(0, bs, bl, pk, ps, oc, ov, busy, done);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.best_seed", bs, 0);
    check("rst.best_len", bl, 0);
    check("rst.peak", pk, 0);
    check("rst.ovf_count", oc, 0);
    check("rst.overflow", ov, 0);
    check("rst.state", dbg32, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply_vec($sformatf("vec%0d", i), vecs[i], 0, 1'b0);

    // Start while busy is ignored; abort together with start in IDLE still starts.
    apply_vec("busy_start", vecs[2], 5, 1'b0);
    apply_vec("abort_with_start", vecs[0], 0, 1'b1);

    // Randomized sweeps checked against the model.
    for (int i = 0; i < 8; i++) begin
      rv.is8 = 0;
      rv.base = $urandom_range(5000, 1);
      rv.cnt = $urandom_range(4, 1);
      model_sweep(32, rv.base, rv.cnt, rv);
      apply_vec($sformatf("rnd32_%0d", i), rv, 0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      rv.is8 = 0;
      rv.base = 64'hFFFF_FFF0 + $urandom_range(12, 0);
      rv.cnt = $urandom_range(24, 4);
      model_sweep(32, rv.base, rv.cnt, rv);
      apply_vec($sformatf("wrap32_%0d", i), rv, 0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      rv.is8 = 1;
      rv.base = $urandom_range(255, 0);
      rv.cnt = $urandom_range(8, 1);
      model_sweep(8, rv.base, rv.cnt, rv);
      apply_vec($sformatf("rnd8_%0d", i), rv, 0, 1'b0);
    end

    // Abort at cycle 50 of seed 27: idle next cycle, no done, nothing committed.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 27, 1);
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, 1'b0, 27, 1);
    end
    drive(0, 1'b0, 1'b1, 27, 1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 27, 1);
    get_out(0, bs, bl, pk, ps, oc, ov, busy, done);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.best_len", bl, 0);
    done_cnt = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      get_out(0, bs, bl, pk, ps, oc, ov, busy, done);
      if (done == 1 || busy == 1) done_cnt++;
    end
    check("abort.no_late_activity", done_cnt, 0);

    // Reset mid-sweep of 1..10 once seed 7 has committed.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1, 10);
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, 1'b0, 1, 10);
    end
    get_out(0, bs, bl, pk, ps, oc, ov, busy, done);
    check("midsweep.best_seed", bs, 7);
    check("midsweep.best_len", bl, 16);
    check("midsweep.busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    get_out(0, bs, bl, pk, ps, oc, ov, busy, done);
    check("areset.busy", busy, 0);
    check("areset.best_seed", bs, 0);
    check("areset.best_len", bl, 0);
    check("areset.peak", pk, 0);
    check("areset.peak_seed", ps, 0);
    check("areset.ovf_count", oc, 0);
    check("areset.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start with a zero seed count is ignored.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 27, 0);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      get_out(0, bs, bl, pk, ps, oc, ov, busy, done);
      if (busy == 1 || done == 1) done_cnt++;
    end
    drive(0, 1'b0, 1'b0, 27, 0);
    check("zero_count.no_activity", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
